sorter_axil_rd_slave: RTL and testbench

//  AXI4-Lite read-channel (AR/R) slave of the data sorter, the read-side counterpart to the AXI4-Lite write slave.

---
 rtl/sorter_axil_pkg.sv | 47 ++++
 rtl/sorter_axil_rd_slave_if.sv | 22 ++
 rtl/sorter_axil_rd_slave.sv | 114 +++++++++++
 tb/tb_sorter_axil_rd_slave.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sorter_axil_pkg.sv
// Shared definitions for the data sorter AXI4-Lite slaves: response codes, register map,
// read FSM encodings and STATUS word layout with its packing helper.
package sorter_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [7:0] ADDR_STATUS = 8'h00;
  localparam logic [7:0] ADDR_VAL    = 8'h04;
  localparam logic [7:0] ADDR_IVAL   = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_RESP  = 2'd3
  } rd_state_e;

  // STATUS word bit positions; [27:24] are reserved and read as zero.
  localparam int STAT_VAL_FULL     = 31;
  localparam int STAT_VAL_EMPTY    = 30;
  localparam int STAT_IVAL_FULL    = 29;
  localparam int STAT_IVAL_EMPTY   = 28;
  localparam int STAT_IVAL_CTR_LSB = 12;
  localparam int STAT_VAL_CTR_LSB  = 0;
  localparam int STAT_CTR_W        = 12;

  function automatic logic [31:0] pack_status(
    input logic                  val_full,
    input logic                  val_empty,
    input logic                  ival_full,
    input logic                  ival_empty,
    input logic [STAT_CTR_W-1:0] ival_ctr,
    input logic [STAT_CTR_W-1:0] val_ctr
  );
    logic [31:0] w;
    w = '0;
    w[STAT_VAL_FULL]   = val_full;
    w[STAT_VAL_EMPTY]  = val_empty;
    w[STAT_IVAL_FULL]  = ival_full;
    w[STAT_IVAL_EMPTY] = ival_empty;
    w[STAT_IVAL_CTR_LSB +: STAT_CTR_W] = ival_ctr;
    w[STAT_VAL_CTR_LSB +: STAT_CTR_W]  = val_ctr;
    return w;
  endfunction

endpackage

// File: rtl/sorter_axil_rd_slave_if.sv
// AXI4-Lite read channel (AR/R) bundle used between the sorter read slave and its master.
// A beat transfers on a rising edge where both VALID and READY are high; once VALID is raised
// its payload stays stable until that edge, and READY may be asserted independently of VALID.
interface sorter_axil_rd_slave_if;
  logic        ARVALID;
  logic [31:0] ARADDR;
  logic        ARREADY;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;

  modport master (
    output ARVALID, ARADDR, RREADY,
    input  ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  ARVALID, ARADDR, RREADY,
    output ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/sorter_axil_rd_slave.sv
// AXI4-Lite read slave of the data sorter: pops the val/ival FIFO or returns STATUS.
// Optional macro SORTER_RD_SLVERR_EN: empty pops and unmapped reads answer SLVERR instead of OKAY.
module sorter_axil_rd_slave
  import sorter_axil_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  sorter_axil_rd_slave_if.slave axil,
  output logic                  val_rd_en,
  input  logic [WIDTH-1:0]      val_rd_data,
  input  logic                  val_empty,
  input  logic                  val_full,
  input  logic [DEPTH-1:0]      val_fifo_ctr,
  output logic                  ival_rd_en,
  input  logic [WIDTH-1:0]      ival_rd_data,
  input  logic                  ival_empty,
  input  logic                  ival_full,
  input  logic [DEPTH-1:0]      ival_fifo_ctr,
  output logic [1:0]            state_o
);

`ifdef SORTER_RD_SLVERR_EN
  localparam logic [1:0] ERR_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] ERR_RESP = RESP_OKAY;
`endif
  localparam int PAD = 32 - WIDTH;

  rd_state_e   state_q;
  logic [7:0]  addr_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rvalid_q;
  logic        arready_q;

  logic             is_status, is_val, is_ival;
  logic             val_pop, ival_pop;
  logic [WIDTH-1:0] head;
  logic [31:0]      status_word;
  logic [31:0]      capt_word;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^axil.ARADDR[31:8];

  always_comb begin
    is_status   = (addr_q == ADDR_STATUS);
    is_val      = (addr_q == ADDR_VAL);
    is_ival     = (addr_q == ADDR_IVAL);
    // Pop strobes depend on the live empty flags, so they are decoded rather than registered.
    val_pop     = (state_q == ST_ISSUE) && is_val  && !val_empty;
    ival_pop    = (state_q == ST_ISSUE) && is_ival && !ival_empty;
    head        = is_ival ? ival_rd_data : val_rd_data;
    capt_word   = 32'(head) << PAD;
    status_word = pack_status(val_full, val_empty, ival_full, ival_empty,
                              STAT_CTR_W'(ival_fifo_ctr), STAT_CTR_W'(val_fifo_ctr));
  end

  assign val_rd_en     = val_pop;
  assign ival_rd_en    = ival_pop;
  assign axil.ARREADY  = arready_q;
  assign axil.RVALID   = rvalid_q;
  assign axil.RDATA    = rdata_q;
  assign axil.RRESP    = rresp_q;
  assign state_o       = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      arready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (axil.ARVALID) begin
            addr_q    <= axil.ARADDR[7:0];
            arready_q <= 1'b0;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (val_pop || ival_pop) begin
            state_q <= ST_CAPT;
          end else begin
            rdata_q  <= is_status ? status_word : 32'h0;
            rresp_q  <= is_status ? RESP_OKAY : ERR_RESP;
            rvalid_q <= 1'b1;
            state_q  <= ST_RESP;
          end
        end
        ST_CAPT: begin
          rdata_q  <= capt_word;
          rresp_q  <= RESP_OKAY;
          rvalid_q <= 1'b1;
          state_q  <= ST_RESP;
        end
        ST_RESP: begin
          if (axil.RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sorter_axil_rd_slave.sv
// Directed bench for sorter_axil_rd_slave: behavioural FIFO heads, AXI-Lite read driver, per-scenario checks.
module tb_sorter_axil_rd_slave;

`ifdef SORTER_RD_SLVERR_EN
  localparam logic [1:0] EXP_ERR = 2'b10;
`else
  localparam logic [1:0] EXP_ERR = 2'b00;
`endif

  logic       clk;
  logic       rst;
  logic       val_rd_en, ival_rd_en;
  logic [7:0] val_rd_data, ival_rd_data;
  logic       val_empty, val_full, ival_empty, ival_full;
  logic [9:0] val_fifo_ctr, ival_fifo_ctr;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int val_pops = 0;
  int ival_pops = 0;
  int bad_pops = 0;
  int rst_pops = 0;

  sorter_axil_rd_slave_if bus();

  sorter_axil_rd_slave #(.WIDTH(8), .DEPTH(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .axil         (bus),
    .val_rd_en    (val_rd_en),
    .val_rd_data  (val_rd_data),
    .val_empty    (val_empty),
    .val_full     (val_full),
    .val_fifo_ctr (val_fifo_ctr),
    .ival_rd_en   (ival_rd_en),
    .ival_rd_data (ival_rd_data),
    .ival_empty   (ival_empty),
    .ival_full    (ival_full),
    .ival_fifo_ctr(ival_fifo_ctr),
    .state_o      (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO head model: val yields A5, A6, ... and ival yields 3C, 3D, ... in pop order
  always @(posedge clk) begin
    if (val_rd_en) begin
      val_rd_data <= 8'hA5 + val_pops[7:0];
      val_pops    <= val_pops + 1;
      if (val_empty) bad_pops <= bad_pops + 1;
    end
    if (ival_rd_en) begin
      ival_rd_data <= 8'h3C + ival_pops[7:0];
      ival_pops    <= ival_pops + 1;
      if (ival_empty) bad_pops <= bad_pops + 1;
    end
    if (rst && (val_rd_en || ival_rd_en)) rst_pops <= rst_pops + 1;
  end

  task automatic set_flags(input logic vf, input logic ve, input logic [9:0] vc,
                           input logic ivf, input logic ive, input logic [9:0] ivc);
    val_full = vf; val_empty = ve; val_fifo_ctr = vc;
    ival_full = ivf; ival_empty = ive; ival_fifo_ctr = ivc;
  endtask

  // driver: one read; lat = edges from AR handshake to the edge ending the first RVALID cycle
  task automatic do_read(input logic [31:0] addr, input int hold,
                         output logic [31:0] data, output logic [1:0] resp,
                         output int lat, output int unstable, output logic tmo);
    int n;
    tmo = 1'b0; unstable = 0; lat = 0; n = 0;
    @(negedge clk);
    bus.ARVALID = 1'b1;
    bus.ARADDR  = addr;
    while (bus.ARREADY !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) tmo = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ARVALID = 1'b0;
    while (bus.RVALID !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (lat >= 20) tmo = 1'b1;
    lat  = lat + 1;
    data = bus.RDATA;
    resp = bus.RRESP;
    repeat (hold) begin
      @(negedge clk);
      if (bus.RVALID !== 1'b1 || bus.RDATA !== data || bus.ARREADY !== 1'b0) unstable++;
    end
    bus.RREADY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.RREADY = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d; logic [1:0] r; int lat, us; logic tmo;
    rst = 1'b1;
    bus.ARVALID = 1'b1;
    bus.ARADDR  = 32'h4;
    set_flags(1'b0, 1'b0, 10'd1, 1'b0, 1'b0, 10'd1);
    repeat (4) @(negedge clk);
    n_checks++; if (bus.ARREADY !== 1'b1) begin n_fail++; $display("FAIL reset_arready got=%b exp=1", bus.ARREADY); end
    n_checks++; if (bus.RVALID !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=0", bus.RVALID); end
    n_checks++; if (bus.RDATA !== 32'h0 || bus.RRESP !== 2'b00) begin n_fail++; $display("FAIL reset_rdata got=%h/%b exp=0/00", bus.RDATA, bus.RRESP); end
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    n_checks++; if (rst_pops !== 0 || val_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got=%0d exp=0", rst_pops); end
    rst = 1'b0;
    bus.ARVALID = 1'b0;
    set_flags(1'b0, 1'b1, 10'd0, 1'b0, 1'b1, 10'd0);
    do_read(32'h0, 0, d, r, lat, us, tmo);
    n_checks++; if (tmo !== 1'b0 || d !== 32'h5000_0000) begin n_fail++; $display("FAIL reset_release got=%h tmo=%b exp=50000000", d, tmo); end
  endtask

  task automatic test_val_pop;
    logic [31:0] d; logic [1:0] r; int lat, us; logic tmo; int p0;
    p0 = val_pops;
    set_flags(1'b0, 1'b0, 10'd2, 1'b0, 1'b1, 10'd0);
    do_read(32'h4, 0, d, r, lat, us, tmo);
    n_checks++; if (d !== 32'hA500_0000 || r !== 2'b00) begin n_fail++; $display("FAIL val_pop1 got=%h/%b exp=a5000000/00", d, r); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL val_pop_latency got=%0d exp=3", lat); end
    do_read(32'h4, 0, d, r, lat, us, tmo);
    n_checks++; if (d !== 32'hA600_0000 || r !== 2'b00) begin n_fail++; $display("FAIL val_pop2 got=%h/%b exp=a6000000/00", d, r); end
    n_checks++; if (val_pops - p0 !== 2 || ival_pops !== 0) begin n_fail++; $display("FAIL val_pop_count got=%0d/%0d exp=2/0", val_pops - p0, ival_pops); end
    set_flags(1'b0, 1'b1, 10'd0, 1'b0, 1'b1, 10'd0);
  endtask

  task automatic test_status;
    logic [31:0] d; logic [1:0] r; int lat, us; logic tmo;
    set_flags(1'b0, 1'b0, 10'd3, 1'b0, 1'b1, 10'd0);
    do_read(32'h0, 0, d, r, lat, us, tmo);
    n_checks++; if (d !== 32'h1000_0003 || r !== 2'b00) begin n_fail++; $display("FAIL status_a got=%h/%b exp=10000003/00", d, r); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL status_latency got=%0d exp=2", lat); end
    set_flags(1'b1, 1'b0, 10'h200, 1'b0, 1'b0, 10'h155);
    do_read(32'hFFFF_FF00, 0, d, r, lat, us, tmo);
    n_checks++; if (d !== 32'h8015_5200) begin n_fail++; $display("FAIL status_b got=%h exp=80155200", d); end
    set_flags(1'b0, 1'b1, 10'h000, 1'b1, 1'b0, 10'h3FF);
    do_read(32'h0, 0, d, r, lat, us, tmo);
    n_checks++; if (d !== 32'h603F_F000) begin n_fail++; $display("FAIL status_c got=%h exp=603ff000", d); end
    n_checks++; if (val_pops !== 2 || ival_pops !== 0) begin n_fail++; $display("FAIL status_no_pop got=%0d/%0d exp=2/0", val_pops, ival_pops); end
    set_flags(1'b0, 1'b1, 10'd0, 1'b0, 1'b1, 10'd0);
  endtask

  task automatic test_ival;
    logic [31:0] d; logic [1:0] r; int lat, us; logic tmo;
    do_read(32'h8, 0, d, r, lat, us, tmo);
    n_checks++; if (d !== 32'h0 || r !== EXP_ERR) begin n_fail++; $display("FAIL ival_empty got=%h/%b exp=0/%b", d, r, EXP_ERR); end
    n_checks++; if (ival_pops !== 0 || lat !== 2) begin n_fail++; $display("FAIL ival_empty_pops got=%0d lat=%0d exp=0 lat=2", ival_pops, lat); end
    set_flags(1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 10'd1);
    do_read(32'h8, 0, d, r, lat, us, tmo);
    n_checks++; if (d !== 32'h3C00_0000 || r !== 2'b00) begin n_fail++; $display("FAIL ival_pop got=%h/%b exp=3c000000/00", d, r); end
    n_checks++; if (ival_pops !== 1 || val_pops !== 2) begin n_fail++; $display("FAIL ival_pop_count got=%0d/%0d exp=1/2", ival_pops, val_pops); end
    set_flags(1'b0, 1'b1, 10'd0, 1'b0, 1'b1, 10'd0);
  endtask

  task automatic test_stall;
    logic [31:0] d; logic [1:0] r; int lat, us; logic tmo;
    set_flags(1'b0, 1'b0, 10'd5, 1'b0, 1'b1, 10'd0);
    do_read(32'h4, 5, d, r, lat, us, tmo);
    n_checks++; if (d !== 32'hA700_0000) begin n_fail++; $display("FAIL stall_data got=%h exp=a7000000", d); end
    n_checks++; if (us !== 0) begin n_fail++; $display("FAIL stall_stable got=%0d exp=0 unstable cycles", us); end
    n_checks++; if (val_pops !== 3) begin n_fail++; $display("FAIL stall_single_pop got=%0d exp=3", val_pops); end
    n_checks++; if (state_o !== 2'd0 || bus.ARREADY !== 1'b1 || bus.RVALID !== 1'b0) begin n_fail++; $display("FAIL stall_release got=st%0d ar%b rv%b exp=st0 ar1 rv0", state_o, bus.ARREADY, bus.RVALID); end
    set_flags(1'b0, 1'b1, 10'd0, 1'b0, 1'b1, 10'd0);
  endtask

  task automatic test_unmapped;
    logic [31:0] d; logic [1:0] r; int lat, us; logic tmo;
    set_flags(1'b0, 1'b0, 10'd4, 1'b0, 1'b0, 10'd4);
    do_read(32'hC, 0, d, r, lat, us, tmo);
    n_checks++; if (d !== 32'h0 || r !== EXP_ERR) begin n_fail++; $display("FAIL unmapped_0c got=%h/%b exp=0/%b", d, r, EXP_ERR); end
    do_read(32'h105, 0, d, r, lat, us, tmo);
    n_checks++; if (d !== 32'h0 || r !== EXP_ERR) begin n_fail++; $display("FAIL unmapped_05 got=%h/%b exp=0/%b", d, r, EXP_ERR); end
    n_checks++; if (val_pops !== 3 || ival_pops !== 1 || bad_pops !== 0) begin n_fail++; $display("FAIL unmapped_pops got=%0d/%0d/%0d exp=3/1/0", val_pops, ival_pops, bad_pops); end
    set_flags(1'b0, 1'b1, 10'd0, 1'b0, 1'b1, 10'd0);
  endtask

  task automatic test_reset_mid;
    logic [31:0] d; logic [1:0] r; int lat, us; logic tmo; int rv_seen;
    rv_seen = 0;
    set_flags(1'b0, 1'b0, 10'd1, 1'b0, 1'b1, 10'd0);
    @(negedge clk);
    bus.ARVALID = 1'b1;
    bus.ARADDR  = 32'h4;
    @(posedge clk);
    @(negedge clk);
    bus.ARVALID = 1'b0;
    n_checks++; if (state_o !== 2'd1 || val_rd_en !== 1'b1) begin n_fail++; $display("FAIL mid_issue got=st%0d en%b exp=st1 en1", state_o, val_rd_en); end
    @(negedge clk);
    n_checks++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL mid_capt got=%0d exp=2", state_o); end
    rst = 1'b1;
    #1;
    n_checks++; if (state_o !== 2'd0 || bus.RVALID !== 1'b0) begin n_fail++; $display("FAIL mid_async got=st%0d rv%b exp=st0 rv0", state_o, bus.RVALID); end
    repeat (3) begin @(negedge clk); if (bus.RVALID !== 1'b0) rv_seen++; end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); if (bus.RVALID !== 1'b0) rv_seen++; end
    n_checks++; if (rv_seen !== 0 || state_o !== 2'd0) begin n_fail++; $display("FAIL mid_no_rvalid got=%0d st%0d exp=0 st0", rv_seen, state_o); end
    n_checks++; if (val_pops !== 4) begin n_fail++; $display("FAIL mid_pop_kept got=%0d exp=4", val_pops); end
    set_flags(1'b0, 1'b1, 10'd0, 1'b0, 1'b1, 10'd0);
    do_read(32'h0, 0, d, r, lat, us, tmo);
    n_checks++; if (tmo !== 1'b0 || d !== 32'h5000_0000) begin n_fail++; $display("FAIL mid_recover got=%h tmo=%b exp=50000000", d, tmo); end
  endtask

  initial begin
    rst = 1'b1;
    bus.ARVALID = 1'b0;
    bus.ARADDR  = 32'h0;
    bus.RREADY  = 1'b0;
    val_rd_data  = 8'h00;
    ival_rd_data = 8'h00;
    set_flags(1'b0, 1'b1, 10'd0, 1'b0, 1'b1, 10'd0);
    test_reset();
    test_val_pop();
    test_status();
    test_ival();
    test_stall();
    test_unmapped();
    test_reset_mid();
    n_checks++; if (bad_pops !== 0) begin n_fail++; $display("FAIL pop_on_empty got=%0d exp=0", bad_pops); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
